// File: rtl/sdhci_dat_pkg.sv
// Shared types and constants for the SDHCI receive-side DAT line engine.
package sdhci_dat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_CRC        = 3'd3,
        ST_END        = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    localparam logic [15:0] CrcPoly     = 16'h1021;
    localparam int unsigned MaxBlockLen = 2048;
    localparam int unsigned BitCntWidth = 14;

    // One serial CRC16-CCITT step, MSB-first shift.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic [15:0] shifted;
        shifted = {crc[14:0], 1'b0};
        if (crc[15] ^ bit_in) begin
            crc16_step = shifted ^ CrcPoly;
        end else begin
            crc16_step = shifted;
        end
    endfunction

endpackage

// File: rtl/sdhci_crc16.sv
// Serial CRC16-CCITT accumulator for a single DAT line.
module sdhci_crc16
    import sdhci_dat_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: clear has priority over a shift.
    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = 16'h0000;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sdhci_dat_rx.sv
// Receive DAT engine: samples one data block in 1/4-bit mode, checks per-line
// CRC16 and end bits, and packs little-endian words into the read buffer.
module sdhci_dat_rx
    import sdhci_dat_pkg::*;
#(
    parameter int unsigned TimeoutWidth = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [11:0]             block_len_i,
    input  logic                    wide_bus_i,
    input  logic [TimeoutWidth-1:0] timeout_i,
    input  logic                    sample_i,
    input  logic [3:0]              dat_i,
    input  logic                    full_i,
    output logic                    push_o,
    output logic [31:0]             data_o,
    output logic                    stall_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    crc_err_o,
    output logic                    end_bit_err_o,
    output logic                    timeout_err_o,
    output logic                    overrun_err_o
);

    state_e                   state_q, state_d, st_nxt_s;
    logic                     wide_q, wide_d;
    logic [BitCntWidth-1:0]   last_q, last_d;
    logic [BitCntWidth-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TimeoutWidth-1:0]  tmo_q, tmo_d;
    logic [TimeoutWidth-1:0]  tick_cnt_q, tick_cnt_d;
    logic [7:0]               byte_q, byte_d;
    logic [31:0]              word_q, word_d;
    logic                     pend_q, pend_d;
    logic [31:0]              pend_data_q, pend_data_d;
    logic                     crc_err_q, crc_err_d;
    logic                     end_err_q, end_err_d;
    logic                     tmo_err_q, tmo_err_d;
    logic                     ovr_err_q, ovr_err_d;

    logic [11:0]              len_masked_s, len_eff_s, len_m1_s;
    logic [BitCntWidth-1:0]   last_idx_s;
    logic [TimeoutWidth-1:0]  tick_inc_s;
    logic [7:0]               byte_new_s;
    logic [31:0]              word_new_s;
    logic                     byte_done_s, word_done_s, word_fire_s;
    logic                     push_s, accept_s;
    logic [3:0]               line_en_s, crc_nz_s;
    logic                     crc_bad_s, end_bad_s, crc_en_s, crc_clear_s;
    logic [15:0]              crc_s [4];

    // Out-of-contract lengths are folded to a legal multiple of 4 so the block always terminates.
    always_comb begin
        len_masked_s = block_len_i & 12'hFFC;
        len_eff_s    = (len_masked_s == 12'h000) ? 12'd4 : len_masked_s;
        len_m1_s     = len_eff_s - 12'd1;
        last_idx_s   = wide_bus_i ? {1'b0, len_m1_s, 1'b1} : {len_m1_s[10:0], 3'b111};
    end

    // Byte/word assembly: bytes arrive MSB first, words fill from the low byte up.
    always_comb begin
        byte_new_s  = wide_q ? {byte_q[3:0], dat_i} : {byte_q[6:0], dat_i[0]};
        byte_done_s = wide_q ? bit_cnt_q[0] : (bit_cnt_q[2:0] == 3'b111);
        word_done_s = byte_done_s & (wide_q ? (bit_cnt_q[2:1] == 2'b11)
                                            : (bit_cnt_q[4:3] == 2'b11));
        word_new_s  = {byte_new_s, word_q[31:8]};
        tick_inc_s  = tick_cnt_q + 1'b1;
        line_en_s   = wide_q ? 4'b1111 : 4'b0001;
        for (int i = 0; i < 4; i++) begin
            crc_nz_s[i] = |crc_s[i];
        end
        crc_bad_s   = |(line_en_s & crc_nz_s);
        end_bad_s   = |(line_en_s & ~dat_i);
        crc_en_s    = sample_i & ((state_q == ST_DATA) | (state_q == ST_CRC));
        crc_clear_s = (state_q == ST_IDLE);
    end

    for (genvar g = 0; g < 4; g++) begin : g_crc
        sdhci_crc16 u_crc (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (crc_clear_s),
            .en_i    (crc_en_s & line_en_s[g]),
            .bit_i   (dat_i[g]),
            .crc_o   (crc_s[g])
        );
    end

    // Receive FSM next-state and datapath updates.
    always_comb begin
        st_nxt_s    = state_q;
        wide_d      = wide_q;
        last_d      = last_q;
        tmo_d       = tmo_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_d      = byte_q;
        word_d      = word_q;
        crc_err_d   = crc_err_q;
        end_err_d   = end_err_q;
        tmo_err_d   = tmo_err_q;
        ovr_err_d   = ovr_err_q;
        word_fire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    st_nxt_s   = ST_WAIT_START;
                    wide_d     = wide_bus_i;
                    last_d     = last_idx_s;
                    tmo_d      = timeout_i;
                    tick_cnt_d = {TimeoutWidth{1'b0}};
                    bit_cnt_d  = 14'd0;
                    byte_d     = 8'h00;
                    word_d     = 32'h0000_0000;
                    crc_err_d  = 1'b0;
                    end_err_d  = 1'b0;
                    tmo_err_d  = 1'b0;
                    ovr_err_d  = 1'b0;
                end else begin
                    st_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_START: begin
                if (sample_i && !dat_i[0]) begin
                    st_nxt_s  = ST_DATA;
                    bit_cnt_d = 14'd0;
                end else if (sample_i) begin
                    tick_cnt_d = tick_inc_s;
                    if (tick_inc_s == tmo_q) begin
                        st_nxt_s  = ST_DONE;
                        tmo_err_d = 1'b1;
                    end else begin
                        st_nxt_s = ST_WAIT_START;
                    end
                end else begin
                    st_nxt_s = ST_WAIT_START;
                end
            end
            ST_DATA: begin
                if (sample_i) begin
                    byte_d      = byte_new_s;
                    word_d      = byte_done_s ? word_new_s : word_q;
                    word_fire_s = word_done_s;
                    if (bit_cnt_q == last_q) begin
                        st_nxt_s  = ST_CRC;
                        bit_cnt_d = 14'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 14'd1;
                    end
                end else begin
                    st_nxt_s = ST_DATA;
                end
            end
            ST_CRC: begin
                if (sample_i && (bit_cnt_q[3:0] == 4'hF)) begin
                    st_nxt_s = ST_END;
                end else if (sample_i) begin
                    bit_cnt_d = bit_cnt_q + 14'd1;
                end else begin
                    st_nxt_s = ST_CRC;
                end
            end
            ST_END: begin
                if (sample_i) begin
                    crc_err_d = crc_bad_s;
                    end_err_d = end_bad_s;
                    st_nxt_s  = ST_DONE;
                end else begin
                    st_nxt_s = ST_END;
                end
            end
            ST_DONE: st_nxt_s = ST_IDLE;
            default: st_nxt_s = ST_IDLE;
        endcase

        // A pending word leaving this cycle frees the slot for a word completing now.
        push_s      = pend_q & ~full_i;
        accept_s    = word_fire_s & ~(pend_q & ~push_s);
        ovr_err_d   = ovr_err_d | (word_fire_s & pend_q & ~push_s);
        pend_data_d = accept_s ? word_new_s : pend_data_q;
        pend_d      = abort_i ? 1'b0 : (accept_s | (pend_q & ~push_s));
        state_d     = abort_i ? ST_IDLE : st_nxt_s;
    end

    // State, datapath and pending-word registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            wide_q      <= 1'b0;
            last_q      <= 14'd0;
            tmo_q       <= {TimeoutWidth{1'b0}};
            tick_cnt_q  <= {TimeoutWidth{1'b0}};
            bit_cnt_q   <= 14'd0;
            byte_q      <= 8'h00;
            word_q      <= 32'h0000_0000;
            pend_q      <= 1'b0;
            pend_data_q <= 32'h0000_0000;
            crc_err_q   <= 1'b0;
            end_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wide_q      <= wide_d;
            last_q      <= last_d;
            tmo_q       <= tmo_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_q      <= byte_d;
            word_q      <= word_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            crc_err_q   <= crc_err_d;
            end_err_q   <= end_err_d;
            tmo_err_q   <= tmo_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    assign push_o        = pend_q & ~full_i;
    assign stall_o       = pend_q & full_i;
    assign data_o        = pend_data_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign crc_err_o     = done_o & crc_err_q;
    assign end_bit_err_o = done_o & end_err_q;
    assign timeout_err_o = done_o & tmo_err_q;
    assign overrun_err_o = done_o & ovr_err_q;

endmodule

// File: tb/tb_sdhci_dat_rx.sv
// Self-checking bench for sdhci_dat_rx: expected words are queued as bytes are
// driven and compared when the DUT pushes them.
module tb_sdhci_dat_rx;

    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, wide, sample, full;
    logic [11:0]   blen;
    logic [TW-1:0] tmo;
    logic [3:0]    dat;
    logic          push_o, stall_o, busy_o, done_o;
    logic [31:0]   data_o;
    logic          crc_err_o, end_bit_err_o, timeout_err_o, overrun_err_o;

    int          total = 0;
    int          bad = 0;
    int          push_cnt = 0;
    int          done_cnt = 0;
    int          stall_cyc = 0;
    logic [3:0]  last_errs = 4'h0;
    logic [31:0] exp_w;
    logic [31:0] exp_q [$];
    time         done_time = 0;
    time         last_tick_time = 0;
    bit          gate_stall = 1'b0;
    logic [7:0]  blk [0:2047];

    sdhci_dat_rx #(.TimeoutWidth(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .block_len_i(blen), .wide_bus_i(wide), .timeout_i(tmo),
        .sample_i(sample), .dat_i(dat), .full_i(full),
        .push_o(push_o), .data_o(data_o), .stall_o(stall_o), .busy_o(busy_o),
        .done_o(done_o), .crc_err_o(crc_err_o), .end_bit_err_o(end_bit_err_o),
        .timeout_err_o(timeout_err_o), .overrun_err_o(overrun_err_o)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every push is checked against the oldest queued word.
    always @(negedge clk) begin
        if (push_o === 1'b1) begin
            push_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL push_unexpected: got %h, required no push", data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if (data_o !== exp_w) begin
                    bad++;
                    $display("FAIL push_data: got %h, required %h", data_o, exp_w);
                end
            end
        end
        if (stall_o === 1'b1) stall_cyc++;
        if (done_o === 1'b1) begin
            done_cnt++;
            done_time = $time;
            last_errs = {crc_err_o, end_bit_err_o, timeout_err_o, overrun_err_o};
        end
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = c << 1;
        if (c[15] != b) r = r ^ 16'h1021;
        return r;
    endfunction

    task automatic tick(input logic [3:0] d);
        int guard = 0;
        while (gate_stall && stall_o === 1'b1 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) begin
            total++; bad++;
            $display("FAIL stall_release: stall_o still 1, required release");
        end
        dat = d; sample = 1'b1;
        @(posedge clk);
        last_tick_time = $time;
        #1;
        sample = 1'b0; dat = 4'hF;
        @(posedge clk); #1;
    endtask

    task automatic send_block(input int len, input int hw_len, input bit w, input int flip_line,
                              input bit bad_end, input int hold_words, input bit gate);
        logic [15:0] crc [4];
        logic [3:0]  d;
        logic [7:0]  b;
        int          pre, wd;
        for (int k = 0; k < 4; k++) crc[k] = 16'h0000;
        gate_stall = gate;
        blen = hw_len[11:0]; wide = w; tmo = 24'd1000;
        full = (hold_words > 0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        if (gate) fork begin repeat (60) @(posedge clk); #1; full = 1'b0; end join_none
        tick(4'hF); tick(4'hF);
        tick(w ? 4'h0 : 4'hE);
        for (int i = 0; i < len; i++) begin
            b = blk[i];
            if (i % 4 == 0) begin
                wd = i / 4;
                if (hold_words > 0 && !gate && wd == hold_words) full = 1'b0;
                if (hold_words == 0 || gate || wd == 0 || wd >= hold_words)
                    exp_q.push_back({blk[i+3], blk[i+2], blk[i+1], blk[i]});
            end
            if (w) begin
                for (int h = 1; h >= 0; h--) begin
                    d = h ? b[7:4] : b[3:0];
                    for (int k = 0; k < 4; k++) crc[k] = crc_upd(crc[k], d[k]);
                    tick(d);
                end
            end else begin
                for (int j = 7; j >= 0; j--) begin
                    crc[0] = crc_upd(crc[0], b[j]);
                    tick({3'b111, b[j]});
                end
            end
        end
        for (int j = 15; j >= 0; j--) begin
            for (int k = 0; k < 4; k++) d[k] = crc[k][j];
            if (!w) d[3:1] = 3'b111;
            if (flip_line >= 0 && j == 3) d[flip_line] = ~d[flip_line];
            tick(d);
        end
        pre = done_cnt;
        tick(bad_end ? (w ? 4'b1011 : 4'b1110) : 4'hF);
        total++;
        if (done_cnt !== pre + 1) begin
            bad++; $display("FAIL done_pulse: got %0d pulses, required 1", done_cnt - pre);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL idle_after_done: busy_o=%b, required 0", busy_o);
        end
        full = 1'b0; gate_stall = 1'b0;
        repeat (4) @(posedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL words_missing: %0d left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_result(input string name, input int p0, input int npush, input logic [3:0] errs);
        total++;
        if (push_cnt - p0 != npush) begin
            bad++; $display("FAIL %s_pushes: got %0d, required %0d", name, push_cnt - p0, npush);
        end
        total++;
        if (last_errs !== errs) begin
            bad++; $display("FAIL %s_errors: got %b, required %b (crc,end,tmo,ovr)", name, last_errs, errs);
        end
    endtask

    task automatic load_deadbeef();
        blk[0] = 8'hDE; blk[1] = 8'hAD; blk[2] = 8'hBE; blk[3] = 8'hEF;
    endtask

    task automatic load_incr();
        for (int i = 0; i < 2048; i++) blk[i] = i[7:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wide = 1'b0; sample = 1'b0;
        full = 1'b0; blen = 12'd4; tmo = 24'd1000; dat = 4'hF;
        repeat (3) @(posedge clk); #1;
        total++;
        if ({push_o, stall_o, busy_o, done_o, crc_err_o, end_bit_err_o, timeout_err_o,
             overrun_err_o, data_o} !== 40'h0) begin
            bad++; $display("FAIL reset_outputs: got %b/%h, required all 0",
                            {push_o, stall_o, busy_o, done_o}, data_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int p0;
        load_deadbeef();
        p0 = push_cnt;
        send_block(4, 4, 1'b0, -1, 1'b0, 0, 1'b0);
        check_result("basic_1bit", p0, 1, 4'b0000);
        load_incr();
        p0 = push_cnt;
        send_block(512, 512, 1'b1, -1, 1'b0, 0, 1'b0);
        check_result("wide_512", p0, 128, 4'b0000);
    endtask

    task automatic test_crc_err();
        int p0;
        load_deadbeef();
        p0 = push_cnt;
        send_block(4, 4, 1'b0, 0, 1'b0, 0, 1'b0);
        check_result("crc_dat0", p0, 1, 4'b1000);
        load_incr();
        p0 = push_cnt;
        send_block(8, 8, 1'b1, 2, 1'b0, 0, 1'b0);
        check_result("crc_dat2", p0, 2, 4'b1000);
    endtask

    task automatic test_timeout();
        int p0, d0;
        p0 = push_cnt;
        blen = 12'd4; wide = 1'b0; tmo = 24'd10;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) tick(4'hF);
        total++;
        if (done_cnt !== d0) begin
            bad++; $display("FAIL timeout_early: got done after 9 ticks, required none");
        end
        tick(4'hF);
        check_result("timeout", p0, 0, 4'b0010);
        total++;
        if (done_time !== last_tick_time + 5) begin
            bad++; $display("FAIL timeout_latency: done at %0t, required %0t", done_time, last_tick_time + 5);
        end
        tick(4'h0);
        total++;
        if (busy_o !== 1'b0 || done_cnt !== d0 + 1) begin
            bad++; $display("FAIL tick_in_idle: busy=%b dones=%0d, required 0 and 1", busy_o, done_cnt - d0);
        end
    endtask

    task automatic test_overrun();
        int p0;
        load_incr();
        stall_cyc = 0; p0 = push_cnt;
        send_block(512, 512, 1'b1, -1, 1'b0, 3, 1'b0);
        check_result("overrun", p0, 126, 4'b0001);
        total++;
        if (stall_cyc == 0) begin bad++; $display("FAIL overrun_stall: got 0 stall cycles, required >0"); end
        stall_cyc = 0; p0 = push_cnt;
        send_block(512, 512, 1'b1, -1, 1'b0, 3, 1'b1);
        check_result("stall_gated", p0, 128, 4'b0000);
        total++;
        if (stall_cyc == 0) begin bad++; $display("FAIL gated_stall: got 0 stall cycles, required >0"); end
    endtask

    task automatic test_abort();
        int p0, d0;
        load_incr();
        p0 = push_cnt; d0 = done_cnt;
        blen = 12'd8; wide = 1'b0; tmo = 24'd1000; full = 1'b1;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        tick(4'hE);
        for (int i = 0; i < 36; i++) tick({3'b111, blk[i/8][7 - (i % 8)]});
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL abort_pre_stall: stall_o=%b, required 1", stall_o); end
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        total++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL abort_idle: busy=%b stall=%b, required 0 0", busy_o, stall_o);
        end
        full = 1'b0;
        tick(4'h0);
        repeat (10) @(posedge clk); #1;
        total++;
        if (done_cnt !== d0 || push_cnt !== p0) begin
            bad++; $display("FAIL abort_quiet: dones=%0d pushes=%0d, required 0 0", done_cnt - d0, push_cnt - p0);
        end
    endtask

    task automatic test_end_bit_and_len();
        int p0;
        load_deadbeef();
        p0 = push_cnt;
        send_block(4, 4, 1'b0, -1, 1'b1, 0, 1'b0);
        check_result("end_bit", p0, 1, 4'b0100);
        p0 = push_cnt;
        send_block(4, 0, 1'b0, -1, 1'b0, 0, 1'b0);
        check_result("len_zero", p0, 1, 4'b0000);
        load_incr();
        p0 = push_cnt;
        send_block(4, 7, 1'b1, -1, 1'b0, 0, 1'b0);
        check_result("len_odd", p0, 1, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_err();
        test_timeout();
        test_overrun();
        test_abort();
        test_end_bit_and_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdhci_dat_rx.md
# sdhci_dat_rx

Receive-side DAT line engine for the SDHCI controller. It samples an SD card data block on DAT[0] (1-bit mode) or DAT[3:0] (4-bit mode) and checks the per-line CRC16. It packs the payload into 32-bit little-endian words and pushes them into the read buffer shift register that backs the Buffer Data Port. It also raises `stall_o` so the SD clock generator can stop the card clock while the buffer is full.

## Interface
Parameters:
- `TimeoutWidth`, default 24: width of the start-bit timeout counter, in sample ticks.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  single-cycle pulse that arms reception of one block; honoured only in IDLE.
- `abort_i`  in  1  synchronous abort, returns to IDLE from any state; wins over `start_i`.
- `block_len_i`  in  12  block length in bytes; multiple of 4, range 4..2048; sampled on `start_i`.
- `wide_bus_i`  in  1  0 = 1-bit mode, 1 = 4-bit mode; sampled on `start_i`.
- `timeout_i`  in  TimeoutWidth  maximum number of sample ticks to wait for the start bit; sampled on `start_i`.
- `sample_i`  in  1  single-cycle strobe marking the SD clock rising edge; `dat_i` is valid in that cycle.
- `dat_i`  in  4  DAT lines, already synchronised to `clk_i`.
- `full_i`  in  1  read buffer full.
- `push_o`  out  1  push strobe to the read buffer.
- `data_o`  out  32  word to push; valid while `push_o` is high.
- `stall_o`  out  1  a completed word is pending; request SD clock stop.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  single-cycle pulse when the block ends (success or error).
- `crc_err_o`, `end_bit_err_o`, `timeout_err_o`, `overrun_err_o`  out  1 each  error flags; pulse only together with `done_o`.

## Operation
- Active lines: DAT[0] only in 1-bit mode, DAT[3:0] in 4-bit mode.
- States:
  - IDLE: `start_i` → WAIT_START; clears the counters, the CRCs and the sticky error bits.
  - WAIT_START: on each tick, if DAT0 = 0 → DATA; otherwise the tick counter increments. Counter = `timeout_i` → DONE with a timeout error.
  - DATA: shifts in `block_len*8` bits (1-bit mode) or `block_len*2` nibbles (4-bit mode). After the last one → CRC.
  - CRC: 16 ticks; each active line shifts its received CRC bit into that line's CRC16. After 16 ticks → END.
  - END: 1 tick. The end bit must be 1 on every active line, otherwise the end-bit error is flagged → DONE.
  - DONE: 1 cycle; `done_o` = 1 together with the accumulated errors → IDLE.
- Bit order: data is sent MSB first within each byte. In 4-bit mode DAT3 carries the MSB of the nibble and the high nibble comes first.
- Packing: the first byte of each 4-byte group goes to `data_o[7:0]` and the fourth to `[31:24]`.
- CRC check: CRC16-CCITT (poly 0x1021, init 0), serial, one instance per active line. The CRC covers the data bits plus the received CRC bits. Any active line with a nonzero residue at END sets the CRC error.
- Push handshake: a completed word moves into the pending register.
  - `push_o` = pending & !`full_i`; pending clears in the same cycle.
  - `stall_o` = pending & `full_i`.
- Overrun: if another word completes while one is still pending, the new word is dropped and the overrun error is set sticky. Reception continues.
- Pending words are still pushed after DONE and after IDLE is reached. `abort_i` discards the pending word.
- `start_i` is ignored while `busy_o` = 1.
- `block_len_i` = 0 or a value that is not a multiple of 4 is out of contract; the block must not hang. It is treated as `block_len_i` & 0xFFC, and a result of 0 is treated as 4.

## Timing
- Reset: all outputs 0, state IDLE, pending cleared.
- `sample_i` at the start bit → DATA state in the next cycle.
- Last bit of a word sampled at cycle t:
  - `push_o` at t+1 if `full_i` = 0;
  - otherwise `stall_o` at t+1, and `push_o` one cycle after `full_i` falls.
- End bit sampled at cycle t → `done_o` at t+1.
- Timeout: at the tick where the counter reaches `timeout_i`, no start bit has been seen → `done_o` at the next cycle.
- Ticks arriving in IDLE or DONE are ignored.
- `abort_i` at cycle t → IDLE, `busy_o` = 0, `stall_o` = 0 at t+1, no `done_o`.
- Reset asserted mid-block → immediate IDLE; no `push_o` or `done_o` pulse.

## Structure
- Package `sdhci_dat_pkg`: state enum, `CrcPoly` = 16'h1021, `MaxBlockLen` = 2048, bit-counter width (14).
- Sub-module `sdhci_crc16`: serial CRC16 with `clear_i`, `en_i`, `bit_i`, `crc_o`; instantiated 4×, lines 1..3 enabled only when `wide_bus_i` = 1.

## Test plan
- 1-bit mode, `block_len` = 4, bytes DE AD BE EF with a correct CRC, `full_i` = 0 → one push of 0xEFBEADDE, `done_o` with all errors 0.
- 4-bit mode, `block_len` = 512 of incrementing bytes with correct per-line CRCs → 128 pushes, the first is 0x03020100, no errors.
- Same as the first case with one CRC bit flipped on DAT0 → all data pushed, `done_o` with `crc_err_o` = 1. In 4-bit mode, flipping DAT2 only → `crc_err_o` = 1.
- `timeout_i` = 10, DAT held high → `done_o` with `timeout_err_o` = 1 exactly 10 ticks after start, no pushes.
- `full_i` held 1 for 3 words of a 512-byte block → `stall_o` high from the first word, and the second word completing sets `overrun_err_o` at `done_o`. With the SD clock correctly stopped while `stall_o` = 1 → no overrun and all words pushed in order.
- `abort_i` mid-DATA and end bit forced to 0 (separate runs) → abort gives IDLE in 1 cycle with no `done_o`; the forced end bit gives `end_bit_err_o` = 1.
